// File: rtl/pl_pkg.sv
// Shared types for the pipeline-stage handshake register.
// Contents:
//   pl_state_t      - occupancy state of a skid-buffered stage
//   PL_MW_W         - width of the MEM/WB bundle (default stage payload)
//   *_t bundles     - packed payloads per pipeline boundary, sized with $bits()
//   occ_of_state()  - number of held entries for a given state
package pl_pkg;

    localparam int unsigned PL_MW_W = 200;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pl_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } id_ex_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu_res;
        logic [63:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } ex_mem_t;

    // 3 x 64 + 5 + 3 = 200 bits, matching PL_MW_W
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu_res;
        logic [63:0] load_data;
        logic [4:0]  rd;
        logic        mem_to_reg;
        logic        wb_en;
        logic        trap;
    } mem_wb_t;

    function automatic logic [1:0] occ_of_state(input pl_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance visibility.
// Ports:
//   clk, reset - clock and asynchronous active-high reset (clears count)
//   inc        - count this cycle
//   count      - current value, holds at all-ones
module sat_counter
    import pl_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already at the maximum value
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pl_stage_hs.sv
// Generic pipeline-stage register with valid/ready handshake, flush and a
// saturating stall counter.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - upstream handshake, in_data payload
//   flush                 - synchronous kill of all held entries
//   out_valid/out_ready   - downstream handshake, out_data payload (registered)
//   occupancy             - held entries (0..2)
//   stall_cnt             - cycles with out_valid && !out_ready, saturating
// SKID=1: two-entry skid buffer, in_ready registered.
// SKID=0: single register, in_ready = !out_valid || out_ready.
module pl_stage_hs
    import pl_pkg::*;
#(
    parameter int unsigned DATA_W = PL_MW_W,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic stall_inc;

    // Stall is counted regardless of flush
    assign stall_inc = out_valid && !out_ready;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    if (SKID != 0) begin : g_skid

        pl_state_t         state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              vld_q, vld_d;
        logic              rdy_q, rdy_d;
        logic [1:0]        occ_q, occ_d;
        logic              in_xfer;
        logic              out_xfer;

        assign in_xfer  = in_valid && rdy_q;
        assign out_xfer = vld_q && out_ready;

        // Next state and payload moves; flush overrides all transfers
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (flush) begin
                state_d = EMPTY;
                main_d  = main_q;
                skid_d  = skid_q;
            end
            // Handshake outputs decode the next state so they leave a flop
            vld_d = (state_d != EMPTY);
            rdy_d = (state_d != TWO);
            occ_d = occ_of_state(state_d);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                vld_q   <= 1'b0;
                rdy_q   <= 1'b1;
                occ_q   <= 2'd0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                vld_q   <= vld_d;
                rdy_q   <= rdy_d;
                occ_q   <= occ_d;
            end
        end

        assign in_ready  = rdy_q;
        assign out_valid = vld_q;
        assign out_data  = main_q;
        assign occupancy = occ_q;

    end else begin : g_single

        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              in_ready_c;
        logic              in_xfer;

        assign in_ready_c = !valid_q || out_ready;
        assign in_xfer    = in_valid && in_ready_c;

        // Load on accept, drain on output-only; flush clears valid
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (in_xfer) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
            if (flush) begin
                valid_d = 1'b0;
                data_d  = data_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in_ready  = in_ready_c;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};

    end

endmodule

// File: tb/tb_pl_stage_hs.sv
// Scoreboard bench for pl_stage_hs: one skid-buffered instance (4-bit stall
// counter) and one single-register instance.
module tb_pl_stage_hs;
    import pl_pkg::*;

    localparam int unsigned DW  = PL_MW_W;
    localparam int unsigned CW1 = 4;
    localparam int unsigned CW0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Skid-buffered instance
    logic           rst1, iv1, ir1, fl1, ov1, or1;
    logic [DW-1:0]  id1, od1;
    logic [1:0]     oc1;
    logic [CW1-1:0] sc1;

    // Single-register instance
    logic           rst0, iv0, ir0, fl0, ov0, or0;
    logic [DW-1:0]  id0, od0;
    logic [1:0]     oc0;
    logic [CW0-1:0] sc0;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] e1, e0;

    pl_stage_hs #(.DATA_W(DW), .SKID(1), .CNT_W(CW1)) dut1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1), .stall_cnt(sc1)
    );

    pl_stage_hs #(.DATA_W(DW), .SKID(0), .CNT_W(CW0)) dut0 (
        .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .flush(fl0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(oc0), .stall_cnt(sc0)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the expected payload on every output handshake
    always @(negedge clk) begin
        if (ov1 && or1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL mon1_unexpected: got %0h, expected no output", od1);
            end else begin
                e1 = q1.pop_front();
                chk_d("mon1_data", od1, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (ov0 && or0) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL mon0_unexpected: got %0h, expected no output", od0);
            end else begin
                e0 = q0.pop_front();
                chk_d("mon0_data", od0, e0);
            end
        end
    end

    initial begin
        bit          mv;
        int unsigned nd;
        logic        irx;

        rst1 = 1'b1; iv1 = 1'b0; id1 = '0; fl1 = 1'b0; or1 = 1'b0;
        rst0 = 1'b1; iv0 = 1'b0; id0 = '0; fl0 = 1'b0; or0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov1", 32'(ov1), 0);
        chk("rst_ir1", 32'(ir1), 1);
        chk("rst_oc1", 32'(oc1), 0);
        chk("rst_sc1", 32'(sc1), 0);
        chk_d("rst_od1", od1, '0);
        chk("rst_ov0", 32'(ov0), 0);
        chk("rst_ir0", 32'(ir0), 1);
        chk_d("rst_od0", od0, '0);
        step();
        rst1 = 1'b0;
        rst0 = 1'b0;
        step();

        // Pass-through, back to back with out_ready=1
        or1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            iv1 = 1'b1;
            id1 = DW'(k);
            q1.push_back(DW'(k));
            @(negedge clk);
            chk("pt_occ", 32'(oc1), (k == 1) ? 0 : 1);
            if (k >= 2) chk_d("pt_lat", od1, DW'(k - 1));
            step();
        end
        iv1 = 1'b0;
        @(negedge clk);
        chk("pt_last_ov", 32'(ov1), 1);
        chk_d("pt_last_od", od1, DW'(8));
        step();
        @(negedge clk);
        chk("pt_drain_ov", 32'(ov1), 0);
        chk("pt_sc", 32'(sc1), 0);
        step();

        // Back-pressure fill: A, B held, C held off until out_ready
        or1 = 1'b0;
        iv1 = 1'b1; id1 = DW'(32'hA); q1.push_back(DW'(32'hA));
        step();
        id1 = DW'(32'hB); q1.push_back(DW'(32'hB));
        step();
        id1 = DW'(32'hC); q1.push_back(DW'(32'hC));
        @(negedge clk);
        chk("bp_occ2", 32'(oc1), 2);
        chk("bp_ir0", 32'(ir1), 0);
        step();
        step();
        or1 = 1'b1;
        @(negedge clk);
        chk("bp_sc", 32'(sc1), 3);
        chk("bp_ir_hold", 32'(ir1), 0);
        step();
        step();
        iv1 = 1'b0;
        step();
        @(negedge clk);
        chk("bp_empty_ov", 32'(ov1), 0);
        chk("bp_empty_oc", 32'(oc1), 0);
        chk("bp_sc_final", 32'(sc1), 3);
        step();

        // Flush from TWO with a simultaneous input (never emitted)
        or1 = 1'b0;
        iv1 = 1'b1; id1 = DW'(32'h11);
        step();
        id1 = DW'(32'h12);
        step();
        fl1 = 1'b1; id1 = DW'(32'hD);
        @(negedge clk);
        chk("fl_pre_occ", 32'(oc1), 2);
        step();
        fl1 = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        chk("fl_ov", 32'(ov1), 0);
        chk("fl_oc", 32'(oc1), 0);
        chk("fl_ir", 32'(ir1), 1);
        chk("fl_sc", 32'(sc1), 5);
        step();
        // Flush from ONE while the input is actually accepted
        iv1 = 1'b1; id1 = DW'(32'h13);
        step();
        fl1 = 1'b1; id1 = DW'(32'hE);
        step();
        fl1 = 1'b0; iv1 = 1'b0;
        @(negedge clk);
        chk("fl1_ov", 32'(ov1), 0);
        chk("fl1_oc", 32'(oc1), 0);
        chk("fl1_sc", 32'(sc1), 6);
        step();
        or1 = 1'b1;
        repeat (3) step();

        // Saturation of the 4-bit stall counter
        or1 = 1'b0;
        iv1 = 1'b1; id1 = DW'(32'h20); q1.push_back(DW'(32'h20));
        step();
        iv1 = 1'b0;
        step();
        @(negedge clk);
        chk("sat_mid", 32'(sc1), 7);
        repeat (19) step();
        @(negedge clk);
        chk("sat_cap", 32'(sc1), 15);
        chk("sat_ov", 32'(ov1), 1);
        chk_d("sat_hold_od", od1, DW'(32'h20));
        step();
        or1 = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("sat_after", 32'(sc1), 15);
        chk("sat_drain", 32'(ov1), 0);
        step();

        // Asynchronous reset mid-cycle while in TWO
        or1 = 1'b0;
        iv1 = 1'b1; id1 = DW'(32'h31);
        step();
        id1 = DW'(32'h32);
        step();
        iv1 = 1'b0;
        @(negedge clk);
        chk("ar_pre_occ", 32'(oc1), 2);
        #1 rst1 = 1'b1;
        #1;
        chk("ar_ov", 32'(ov1), 0);
        chk("ar_oc", 32'(oc1), 0);
        chk("ar_ir", 32'(ir1), 1);
        chk("ar_sc", 32'(sc1), 0);
        chk_d("ar_od", od1, '0);
        step();
        rst1 = 1'b0;
        step();
        or1 = 1'b1;
        iv1 = 1'b1; id1 = DW'(32'h40); q1.push_back(DW'(32'h40));
        step();
        iv1 = 1'b0;
        chk("ar_lat_ov", 32'(ov1), 1);
        chk_d("ar_lat_od", od1, DW'(32'h40));
        step();
        @(negedge clk);
        chk("ar_drain", 32'(ov1), 0);
        chk("q1_empty", 32'(q1.size()), 0);
        step();

        // Single-register mode: continuous stream, out_ready toggling
        mv = 1'b0;
        nd = 32'h100;
        for (int c = 0; c < 16; c++) begin
            or0 = ((c % 2) == 1);
            iv0 = 1'b1;
            id0 = DW'(nd);
            #1;
            irx = !mv || or0;
            chk("s0_ir", 32'(ir0), 32'(irx));
            chk("s0_ov", 32'(ov0), 32'(mv));
            chk("s0_oc", 32'(oc0), 32'(mv));
            if (irx) begin
                q0.push_back(DW'(nd));
                nd++;
                mv = 1'b1;
            end
            step();
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("s0_drain", 32'(ov0), 0);
        chk("q0_empty", 32'(q0.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
